// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised UART receiver. It supports a configurable data width, parity,
// stop bits and oversampling. Each bit is decided by a 3-sample majority vote
// near mid-bit. Start bits that do not hold low at mid-bit are rejected. The
// receiver flags parity, framing and overrun errors. Each received word is
// handed to the consumer over a valid/ready handshake.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   rx           in   asynchronous serial line, idle high
//   data_out     out  received word [DATA_BITS-1:0], LSB = first bit on line
//   data_valid   out  data_out and the error flags hold a word
//   data_ready   in   consumer accepts the word on a cycle with data_valid=1
//   parity_err   out  parity mismatch for the held word (0 when PARITY=0)
//   frame_err    out  a stop bit was sampled 0 for the held word
//   overrun_err  out  one-cycle pulse: a completed word was dropped
//   busy         out  receiver is inside a frame (state != IDLE)
//
// Handshake: a word is transferred on every clock edge where data_valid=1
// and data_ready=1. data_valid remains high until that edge. data_out,
// parity_err and frame_err do not change while data_valid=1. data_ready is
// ignored while data_valid=0. If a new word completes on the same edge as a
// transfer, the new word replaces the old one and data_valid stays high.
// If a new word completes while an untransferred word is still held, the
// new word is dropped and overrun_err pulses.
// ----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CLKS_PER_TICK = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int SW = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_TICK - 1);
    localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_DEC   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    // Elaboration-time parameter checks
    if (CLKS_PER_TICK < 2) begin : g_bad_tick
        $error("uart_rx_param: CLKS_PER_TICK must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_armed;
    logic [CW-1:0]        r_clk_cnt;
    logic [SW-1:0]        r_smp_cnt;
    logic [3:0]           r_bit_cnt;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_frame_acc;
    logic                 r_commit;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_tick;
    logic w_decide;
    logic w_bit_end;
    logic w_vote;
    logic w_start;
    logic w_par_exp;
    logic w_final_stop;

    assign w_tick    = (r_clk_cnt == CLK_LAST);
    assign w_decide  = w_tick && (r_smp_cnt == SMP_DEC);
    assign w_bit_end = w_tick && (r_smp_cnt == SMP_LAST);
    // The third sample is the live synchronised line at the decision tick
    assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
    // r_armed records that the line has been seen high since IDLE was entered.
    // A held break therefore cannot retrigger the receiver.
    assign w_start   = (r_state == S_IDLE) && r_armed && !r_rx_sync;
    assign w_par_exp = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
    assign w_final_stop = (r_state == S_STOP) && w_decide && (r_bit_cnt == STOP_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_next = S_START;
            end
            S_START: begin
                if (w_decide && w_vote)  w_state_next = S_IDLE;
                else if (w_bit_end)      w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && r_bit_cnt == DATA_LAST)
                    w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                // Leave at mid-bit so the next start edge is never missed
                if (w_final_stop) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: synchroniser, timing counters, sampling, shifting, output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_armed      <= 1'b0;
            r_clk_cnt    <= '0;
            r_smp_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_frame_acc  <= 1'b0;
            r_commit     <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;

            r_armed <= (r_state == S_IDLE) ? (r_armed | r_rx_sync) : 1'b0;

            // Counters idle at zero, which also clears them on the start edge
            if (r_state == S_IDLE) begin
                r_clk_cnt <= '0;
                r_smp_cnt <= '0;
            end else if (w_tick) begin
                r_clk_cnt <= '0;
                r_smp_cnt <= (r_smp_cnt == SMP_LAST) ? '0 : r_smp_cnt + 1'b1;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end

            if (w_tick && r_smp_cnt == SMP_A) r_s0 <= r_rx_sync;
            if (w_tick && r_smp_cnt == SMP_B) r_s1 <= r_rx_sync;

            // Bit index restarts whenever the FSM moves to a new field
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end) begin
                r_bit_cnt <= (w_state_next != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
            end

            // LSB arrives first, so shifting in at the MSB leaves it at bit 0
            if (r_state == S_DATA && w_decide) begin
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            end

            if (w_start) begin
                r_par_acc <= 1'b0;
            end else if (r_state == S_PARITY && w_decide) begin
                r_par_acc <= w_vote ^ w_par_exp;
            end

            if (w_start) begin
                r_frame_acc <= 1'b0;
            end else if (r_state == S_STOP && w_decide && !w_vote) begin
                r_frame_acc <= 1'b1;
            end

            // Deliver one cycle after the final stop decision. r_frame_acc
            // then includes that final stop bit.
            r_commit  <= w_final_stop;
            r_overrun <= r_commit && r_data_valid && !data_ready;

            if (r_commit && (!r_data_valid || data_ready)) begin
                r_data_out   <= r_shift;
                r_parity_err <= r_par_acc;
                r_frame_err  <= r_frame_acc;
                r_data_valid <= 1'b1;
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun;
    assign busy        = (r_state != S_IDLE);

endmodule
